ppi_rw_control: RTL and testbench

- Read/write control sequencer for the 8255-style PPI.
- Synchronises the asynchronous host strobes (CS_N, RD_N, WR_N) and steers the data bus buffer direction.
- On writes, issues one-cycle load strobes to port latches A/B/C, the control-word register, or the port-C bit set/reset logic.
- Sits between the system bus pins and the data bus buffer / port blocks.

---
 rtl/ppi_rw_control.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ppi_rw_control.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_rw_control.sv
// ---------------------------------------------------------------------------
// ppi_rw_control
// Read/write control sequencer for an 8255-style PPI. The asynchronous host
// strobes are synchronised, the data bus buffer direction is steered, and
// writes are turned into one-cycle load strobes for the port latches, the
// control-word register or the port-C bit set/reset logic.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   cs_n         chip select, active low, asynchronous
//   rd_n         read strobe, active low, asynchronous
//   wr_n         write strobe, active low, asynchronous
//   addr[1:0]    register select (0=A, 1=B, 2=C, 3=control)
//   din[7:0]     write data from the data bus buffer
//   bus_drive    1 = buffer drives the host data pins from internal data
//   rd_active    read cycle in progress
//   rd_sel[1:0]  address latched at the start of the current read
//   wr_data[7:0] last committed write data
//   wr_strobe[2:0] one-hot one-cycle load for port A/B/C
//   ctrl_word[7:0] current control word
//   ctrl_load    one-cycle pulse when ctrl_word is updated
//   bsr_strobe   one-cycle port-C bit set/reset pulse
//   bsr_bit[2:0] bit index for the set/reset operation
//   bsr_val      value for the set/reset operation
//   busy         sequencer not idle
//   err_illegal  one-cycle pulse on an illegal access
// ---------------------------------------------------------------------------
module ppi_rw_control #(
   parameter int SYNC_STAGES     = 2,
   parameter int RECOVERY_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic       bus_drive,
   output logic       rd_active,
   output logic [1:0] rd_sel,
   output logic [7:0] wr_data,
   output logic [2:0] wr_strobe,
   output logic [7:0] ctrl_word,
   output logic       ctrl_load,
   output logic       bsr_strobe,
   output logic [2:0] bsr_bit,
   output logic       bsr_val,
   output logic       busy,
   output logic       err_illegal
);

   // Out-of-range parameters are clamped to their smallest working values.
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int REC_N  = (RECOVERY_CYCLES < 1) ? 1 : RECOVERY_CYCLES;
   localparam int CNT_W  = (REC_N > 1) ? $clog2(REC_N) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REC_N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [7:0]       CTRL_RESET = 8'h9B;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_WRITE   = 3'd2,
      ST_COMMIT  = 3'd3,
      ST_RECOVER = 3'd4
   } state_t;

   // Address to port-latch one-hot load vector; the control address maps to none.
   function automatic logic [2:0] port_onehot(input logic [1:0] a);
      case (a)
         2'd0:    port_onehot = 3'b001;
         2'd1:    port_onehot = 3'b010;
         2'd2:    port_onehot = 3'b100;
         default: port_onehot = 3'b000;
      endcase
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic [SYNC_N-1:0] cs_sync_r;
   logic [SYNC_N-1:0] rd_sync_r;
   logic [SYNC_N-1:0] wr_sync_r;
   logic              cs_s;
   logic              rd_s;
   logic              wr_s;
   logic [1:0]        wr_addr_r;
   logic [7:0]        data_lat_r;
   logic [CNT_W-1:0]  rec_cnt_r;
   logic              illegal_seen_r;

   logic              illegal_s;
   logic              read_entry_s;
   logic              commit_s;
   logic              ctrl_commit_s;
   logic              bsr_commit_s;
   logic [7:0]        data_nxt_s;
   logic [1:0]        rd_sel_nxt_s;

   logic              bus_drive_r;
   logic              rd_active_r;
   logic [1:0]        rd_sel_r;
   logic [7:0]        wr_data_r;
   logic [2:0]        wr_strobe_r;
   logic [7:0]        ctrl_word_r;
   logic              ctrl_load_r;
   logic              bsr_strobe_r;
   logic [2:0]        bsr_bit_r;
   logic              bsr_val_r;
   logic              busy_r;
   logic              err_illegal_r;

   assign cs_s = cs_sync_r[SYNC_N-1];
   assign rd_s = rd_sync_r[SYNC_N-1];
   assign wr_s = wr_sync_r[SYNC_N-1];

   // Synchroniser chains for the host strobes; idle (high) out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_r <= {SYNC_N{1'b1}};
         rd_sync_r <= {SYNC_N{1'b1}};
         wr_sync_r <= {SYNC_N{1'b1}};
      end else begin
         cs_sync_r <= {cs_sync_r[SYNC_N-2:0], cs_n};
         rd_sync_r <= {rd_sync_r[SYNC_N-2:0], rd_n};
         wr_sync_r <= {wr_sync_r[SYNC_N-2:0], wr_n};
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!cs_s && !rd_s && wr_s) begin
               state_nxt_s = ST_READ;
            end else if (!cs_s && !wr_s && rd_s) begin
               state_nxt_s = ST_WRITE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: begin
            if (rd_s || cs_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_READ;
            end
         end
         ST_WRITE: begin
            // A rising write strobe commits even if chip select left too.
            if (wr_s) begin
               state_nxt_s = ST_COMMIT;
            end else if (cs_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WRITE;
            end
         end
         ST_COMMIT: begin
            state_nxt_s = ST_RECOVER;
         end
         ST_RECOVER: begin
            if (rec_cnt_r == CNT_ZERO) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RECOVER;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Transition qualifiers that feed the registered outputs.
   always_comb begin
      illegal_s    = (state_r == ST_IDLE) && !cs_s && !rd_s && !wr_s;
      read_entry_s = (state_r == ST_IDLE) && (state_nxt_s == ST_READ);
      commit_s     = (state_nxt_s == ST_COMMIT);
      // The commit edge must see the same din that data_lat captures on it.
      if (state_r == ST_WRITE) begin
         data_nxt_s = din;
      end else begin
         data_nxt_s = data_lat_r;
      end
      if (read_entry_s) begin
         rd_sel_nxt_s = addr;
      end else begin
         rd_sel_nxt_s = rd_sel_r;
      end
      ctrl_commit_s = commit_s && (wr_addr_r == 2'd3) && data_nxt_s[7];
      bsr_commit_s  = commit_s && (wr_addr_r == 2'd3) && !data_nxt_s[7];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Write address/data capture, recovery counter and illegal-episode flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_r      <= 2'd0;
         data_lat_r     <= 8'h00;
         rec_cnt_r      <= CNT_ZERO;
         illegal_seen_r <= 1'b0;
      end else begin
         if ((state_r == ST_IDLE) && (state_nxt_s == ST_WRITE)) begin
            wr_addr_r <= addr;
         end
         data_lat_r <= data_nxt_s;
         if (state_r == ST_COMMIT) begin
            rec_cnt_r <= CNT_LOAD;
         end else if ((state_r == ST_RECOVER) && (rec_cnt_r != CNT_ZERO)) begin
            rec_cnt_r <= rec_cnt_r - CNT_ONE;
         end
         // Report a stuck read+write collision once, not every cycle.
         illegal_seen_r <= illegal_s;
      end
   end

   // Registered outputs, decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_drive_r   <= 1'b0;
         rd_active_r   <= 1'b0;
         rd_sel_r      <= 2'd0;
         wr_data_r     <= 8'h00;
         wr_strobe_r   <= 3'b000;
         ctrl_word_r   <= CTRL_RESET;
         ctrl_load_r   <= 1'b0;
         bsr_strobe_r  <= 1'b0;
         bsr_bit_r     <= 3'd0;
         bsr_val_r     <= 1'b0;
         busy_r        <= 1'b0;
         err_illegal_r <= 1'b0;
      end else begin
         rd_active_r <= (state_nxt_s == ST_READ);
         // The control register is write-only: never drive the bus for it.
         bus_drive_r <= (state_nxt_s == ST_READ) && (rd_sel_nxt_s != 2'd3);
         rd_sel_r    <= rd_sel_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
         if (commit_s) begin
            wr_data_r   <= data_nxt_s;
            wr_strobe_r <= port_onehot(wr_addr_r);
         end else begin
            wr_strobe_r <= 3'b000;
         end
         if (ctrl_commit_s) begin
            ctrl_word_r <= data_nxt_s;
         end
         ctrl_load_r  <= ctrl_commit_s;
         bsr_strobe_r <= bsr_commit_s;
         if (bsr_commit_s) begin
            bsr_bit_r <= data_nxt_s[3:1];
            bsr_val_r <= data_nxt_s[0];
         end
         err_illegal_r <= (illegal_s && !illegal_seen_r) ||
                          (read_entry_s && (addr == 2'd3));
      end
   end

   assign bus_drive   = bus_drive_r;
   assign rd_active   = rd_active_r;
   assign rd_sel      = rd_sel_r;
   assign wr_data     = wr_data_r;
   assign wr_strobe   = wr_strobe_r;
   assign ctrl_word   = ctrl_word_r;
   assign ctrl_load   = ctrl_load_r;
   assign bsr_strobe  = bsr_strobe_r;
   assign bsr_bit     = bsr_bit_r;
   assign bsr_val     = bsr_val_r;
   assign busy        = busy_r;
   assign err_illegal = err_illegal_r;

endmodule

// File: tb/tb_ppi_rw_control.sv
// ---------------------------------------------------------------------------
// tb_ppi_rw_control
// Directed self-checking bench for ppi_rw_control (default parameters:
// two synchroniser stages, two recovery cycles). A table of write
// transactions with hand-computed results is applied in a loop; reads,
// illegal accesses, aborts, recovery hold-off and reset are hand sequences.
// ---------------------------------------------------------------------------
module tb_ppi_rw_control;

   logic       clk;
   logic       rst_n;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic [1:0] addr;
   logic [7:0] din;
   logic       bus_drive;
   logic       rd_active;
   logic [1:0] rd_sel;
   logic [7:0] wr_data;
   logic [2:0] wr_strobe;
   logic [7:0] ctrl_word;
   logic       ctrl_load;
   logic       bsr_strobe;
   logic [2:0] bsr_bit;
   logic       bsr_val;
   logic       busy;
   logic       err_illegal;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [1:0] addr;
      logic [7:0] din;
      logic [2:0] exp_strobe;
      logic       exp_cload;
      logic       exp_bsr;
      logic [7:0] exp_ctrl;
      logic [2:0] exp_bit;
      logic       exp_val;
   } wvec_t;

   wvec_t tbl [8];

   ppi_rw_control dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cs_n        (cs_n),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .addr        (addr),
      .din         (din),
      .bus_drive   (bus_drive),
      .rd_active   (rd_active),
      .rd_sel      (rd_sel),
      .wr_data     (wr_data),
      .wr_strobe   (wr_strobe),
      .ctrl_word   (ctrl_word),
      .ctrl_load   (ctrl_load),
      .bsr_strobe  (bsr_strobe),
      .bsr_bit     (bsr_bit),
      .bsr_val     (bsr_val),
      .busy        (busy),
      .err_illegal (err_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [4:0] seen;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      addr = 2'd0;  din = 8'h00;

      //        addr   din    strobe  cld   bsr   ctrl   bit   val
      tbl[0] = '{2'd0, 8'h11, 3'b001, 1'b0, 1'b0, 8'h9B, 3'd0, 1'b0};
      tbl[1] = '{2'd1, 8'hA5, 3'b010, 1'b0, 1'b0, 8'h9B, 3'd0, 1'b0};
      tbl[2] = '{2'd2, 8'h3C, 3'b100, 1'b0, 1'b0, 8'h9B, 3'd0, 1'b0};
      tbl[3] = '{2'd3, 8'h80, 3'b000, 1'b1, 1'b0, 8'h80, 3'd0, 1'b0};
      tbl[4] = '{2'd3, 8'h0B, 3'b000, 1'b0, 1'b1, 8'h80, 3'd5, 1'b1};
      tbl[5] = '{2'd3, 8'h06, 3'b000, 1'b0, 1'b1, 8'h80, 3'd3, 1'b0};
      tbl[6] = '{2'd3, 8'h9B, 3'b000, 1'b1, 1'b0, 8'h9B, 3'd3, 1'b0};
      tbl[7] = '{2'd1, 8'hFF, 3'b010, 1'b0, 1'b0, 8'h9B, 3'd3, 1'b0};

      // Reset values.
      repeat (3) tick();
      chk("rst_ctrl_word", 32'(ctrl_word), 32'h9B);
      chk("rst_bus_drive", 32'(bus_drive), 32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      chk("rst_strobes",   32'({wr_strobe, ctrl_load, bsr_strobe, err_illegal}), 32'h0);
      chk("rst_wr_data",   32'(wr_data),   32'h0);
      chk("rst_rd_sel",    32'(rd_sel),    32'h0);
      rst_n = 1'b1;
      repeat (4) tick();

      // Table-driven writes: wr_n low 4 clocks, strobe on edge 3 after rise.
      for (int i = 0; i < 8; i++) begin
         addr = tbl[i].addr; din = tbl[i].din; cs_n = 1'b0; wr_n = 1'b0;
         repeat (4) tick();
         chk("wr_busy_during", 32'(busy), 32'h1);
         wr_n = 1'b1;
         repeat (2) tick();
         chk("wr_strobe_early", 32'({wr_strobe, ctrl_load, bsr_strobe}), 32'h0);
         tick();
         chk("wr_strobe",  32'(wr_strobe),  32'(tbl[i].exp_strobe));
         chk("ctrl_load",  32'(ctrl_load),  32'(tbl[i].exp_cload));
         chk("bsr_strobe", 32'(bsr_strobe), 32'(tbl[i].exp_bsr));
         chk("ctrl_word",  32'(ctrl_word),  32'(tbl[i].exp_ctrl));
         chk("wr_data",    32'(wr_data),    32'(tbl[i].din));
         chk("bsr_bit",    32'(bsr_bit),    32'(tbl[i].exp_bit));
         chk("bsr_val",    32'(bsr_val),    32'(tbl[i].exp_val));
         cs_n = 1'b1;
         tick();
         chk("wr_strobe_len", 32'({wr_strobe, ctrl_load, bsr_strobe}), 32'h0);
         chk("recover_busy1", 32'(busy), 32'h1);
         tick();
         chk("recover_busy2", 32'(busy), 32'h1);
         tick();
         chk("recover_done", 32'(busy), 32'h0);
         chk("wr_data_hold", 32'(wr_data), 32'(tbl[i].din));
         repeat (2) tick();
      end

      // Read of port C: rd_n low 5 clocks.
      addr = 2'd2; cs_n = 1'b0; rd_n = 1'b0;
      repeat (2) tick();
      chk("rd_drive_early", 32'(bus_drive), 32'h0);
      tick();
      chk("rd_drive",  32'(bus_drive), 32'h1);
      chk("rd_active", 32'(rd_active), 32'h1);
      chk("rd_sel",    32'(rd_sel),    32'h2);
      chk("rd_no_err", 32'(err_illegal), 32'h0);
      repeat (2) tick();
      chk("rd_drive_hold", 32'(bus_drive), 32'h1);
      rd_n = 1'b1;
      repeat (2) tick();
      chk("rd_drive_tail", 32'(bus_drive), 32'h1);
      tick();
      chk("rd_drive_off",  32'(bus_drive), 32'h0);
      chk("rd_active_off", 32'(rd_active), 32'h0);
      chk("rd_busy_off",   32'(busy),      32'h0);
      cs_n = 1'b1;
      repeat (3) tick();

      // Read of the write-only control register.
      addr = 2'd3; cs_n = 1'b0; rd_n = 1'b0;
      repeat (3) tick();
      chk("rd3_drive",  32'(bus_drive),   32'h0);
      chk("rd3_active", 32'(rd_active),   32'h1);
      chk("rd3_err",    32'(err_illegal), 32'h1);
      chk("rd3_sel",    32'(rd_sel),      32'h3);
      tick();
      chk("rd3_err_once", 32'(err_illegal), 32'h0);
      chk("rd3_drive2",   32'(bus_drive),   32'h0);
      rd_n = 1'b1; cs_n = 1'b1;
      repeat (4) tick();
      chk("rd3_released", 32'(rd_active), 32'h0);

      // Read and write strobes together.
      addr = 2'd0; din = 8'h44; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
      repeat (3) tick();
      chk("ill_err",  32'(err_illegal), 32'h1);
      chk("ill_busy", 32'(busy),        32'h0);
      tick();
      chk("ill_stay", 32'({busy, rd_active, bus_drive, wr_strobe}), 32'h0);
      cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      repeat (4) tick();

      // cs_n rises before wr_n: write aborted.
      addr = 2'd0; din = 8'h77; cs_n = 1'b0; wr_n = 1'b0; seen = 5'd0;
      repeat (4) tick();
      cs_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         seen = seen | {wr_strobe, ctrl_load, bsr_strobe};
      end
      chk("abort_idle", 32'(busy), 32'h0);
      wr_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         seen = seen | {wr_strobe, ctrl_load, bsr_strobe};
      end
      chk("abort_no_strobe", 32'(seen),    32'h0);
      chk("abort_wr_data",   32'(wr_data), 32'hFF);

      // New write during recovery is held off until recovery ends.
      addr = 2'd0; din = 8'h12; cs_n = 1'b0; wr_n = 1'b0;
      repeat (4) tick();
      wr_n = 1'b1;
      repeat (3) tick();
      chk("hold_first_strobe", 32'(wr_strobe), 32'h1);
      addr = 2'd3; din = 8'h8A; wr_n = 1'b0;
      tick();
      chk("hold_busy1", 32'(busy), 32'h1);
      tick();
      chk("hold_busy2", 32'(busy), 32'h1);
      tick();
      chk("hold_idle", 32'(busy), 32'h0);
      tick();
      chk("hold_accept", 32'(busy), 32'h1);
      tick();
      wr_n = 1'b1;
      repeat (2) tick();
      chk("hold_cload_early", 32'(ctrl_load), 32'h0);
      tick();
      chk("hold_cload", 32'(ctrl_load), 32'h1);
      chk("hold_ctrl",  32'(ctrl_word), 32'h8A);
      chk("hold_data",  32'(wr_data),   32'h8A);
      cs_n = 1'b1;
      repeat (4) tick();

      // Reset asserted mid-WRITE.
      addr = 2'd1; din = 8'h55; cs_n = 1'b0; wr_n = 1'b0; seen = 5'd0;
      repeat (4) tick();
      chk("midwr_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      #2;
      chk("midwr_rst_busy",  32'(busy),      32'h0);
      chk("midwr_rst_drive", 32'(bus_drive), 32'h0);
      chk("midwr_rst_ctrl",  32'(ctrl_word), 32'h9B);
      chk("midwr_rst_data",  32'(wr_data),   32'h0);
      wr_n = 1'b1; cs_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         seen = seen | {wr_strobe, ctrl_load, bsr_strobe};
      end
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         seen = seen | {wr_strobe, ctrl_load, bsr_strobe};
      end
      chk("midwr_no_strobe", 32'(seen),      32'h0);
      chk("midwr_ctrl_kept", 32'(ctrl_word), 32'h9B);
      chk("midwr_idle",      32'(busy),      32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
